// File: rtl/status_flag_unit_if.sv
// Pipeline-side signal bundle for status_flag_unit: EXE flag write, ID condition query,
// exception save/restore requests, and the flag/status outputs.
interface status_flag_unit_if #(
  parameter int CNT_W = 16
);
  logic             freeze;
  logic             exe_valid;
  logic             exe_s;
  logic [3:0]       alu_nzcv;
  logic             id_valid;
  logic [3:0]       id_cond;
  logic             save_req;
  logic             restore_req;
  logic [3:0]       sr;
  logic [3:0]       cond_nzcv;
  logic             flag_hazard;
  logic             shadow_valid;
  logic [CNT_W-1:0] flag_writes;

  modport master (
    output freeze, exe_valid, exe_s, alu_nzcv, id_valid, id_cond, save_req, restore_req,
    input  sr, cond_nzcv, flag_hazard, shadow_valid, flag_writes
  );

  modport slave (
    input  freeze, exe_valid, exe_s, alu_nzcv, id_valid, id_cond, save_req, restore_req,
    output sr, cond_nzcv, flag_hazard, shadow_valid, flag_writes
  );
endinterface

// File: rtl/status_flag_unit.sv
// NZCV status register with one-entry exception shadow and flag RAW hazard detection.
// Define STATUS_FLAG_FWD_EN to bypass same-cycle flag updates to the condition checker instead.
module status_flag_unit #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  status_flag_unit_if.slave  bus
);
  logic [3:0]       r_sr;
  logic [3:0]       r_shadow;
  logic             r_shadow_valid;
  logic [CNT_W-1:0] r_flag_writes;

  logic             w_wr;
  logic [3:0]       w_nxt;
  logic             w_restore;
  logic             w_swap;

  always_comb begin
    w_wr      = bus.exe_valid & bus.exe_s;
    w_nxt     = w_wr ? bus.alu_nzcv : r_sr;
    w_restore = bus.restore_req & r_shadow_valid;
    w_swap    = w_restore & bus.save_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr           <= '0;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
      r_flag_writes  <= '0;
    end else if (!bus.freeze) begin
      if (w_swap) begin
        r_sr     <= r_shadow;
        r_shadow <= w_nxt;
      end else if (w_restore) begin
        r_sr           <= r_shadow;
        r_shadow_valid <= 1'b0;
      end else begin
        // A save still commits nxt to sr; only the shadow copy is added.
        r_sr <= w_nxt;
        if (bus.save_req) begin
          r_shadow       <= w_nxt;
          r_shadow_valid <= 1'b1;
        end
      end
      // Any valid restore (including swap) discards the ALU value from the count.
      if (w_wr && !w_restore) begin
        r_flag_writes <= r_flag_writes + CNT_W'(1);
      end
    end
  end

  assign bus.sr           = r_sr;
  assign bus.shadow_valid = r_shadow_valid;
  assign bus.flag_writes  = r_flag_writes;

`ifdef STATUS_FLAG_FWD_EN
  assign bus.cond_nzcv   = w_restore ? r_shadow : w_nxt;
  assign bus.flag_hazard = 1'b0;
`else
  logic w_uses_flags;

  always_comb begin
    w_uses_flags = bus.id_valid & (bus.id_cond != 4'd14) & (bus.id_cond != 4'd15);
  end

  assign bus.cond_nzcv   = r_sr;
  assign bus.flag_hazard = w_uses_flags & (w_wr | w_restore) & ~rst;
`endif
endmodule
